nes_controller_device: RTL and testbench

Device-side emulation of an NES controller (4021-style parallel-in/serial-out shift register). It presents locally sourced button state to an external NES host or console over the latch/clk/data wires. The block sits between on-board button sources (debounced switches, UART-injected state, test patterns) and the controller connector. It runs on the 50 MHz board clock and treats the host's latch and clk as asynchronous inputs.

---
 rtl/nes_pkg.sv | 25 ++
 rtl/nes_controller_device_if.sv | 25 ++
 rtl/nes_input_sync.sv | 78 +++++++
 rtl/nes_controller_device.sv | 127 ++++++++++++
 tb/tb_nes_controller_device.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/nes_pkg.sv
// Shared constants for the NES controller device: button bit mapping, frame width and FSM encoding.
// Host-side drivers import the same BTN_* mapping so both ends agree on bit order.
package nes_pkg;

    localparam int unsigned NES_BITS = 8;

    localparam int unsigned BTN_A      = 0;
    localparam int unsigned BTN_B      = 1;
    localparam int unsigned BTN_SELECT = 2;
    localparam int unsigned BTN_START  = 3;
    localparam int unsigned BTN_UP     = 4;
    localparam int unsigned BTN_DOWN   = 5;
    localparam int unsigned BTN_LEFT   = 6;
    localparam int unsigned BTN_RIGHT  = 7;

    localparam logic [3:0] BIT_LAST = 4'd7;
    localparam logic [3:0] BIT_FILL = 4'd8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } nes_state_e;

endpackage

// File: rtl/nes_controller_device_if.sv
// Connector-side and button-side signal bundle of the NES controller device.
// master = host/stimulus side, slave = the controller device itself.
interface nes_controller_device_if;
    import nes_pkg::*;

    logic                nes_latch;
    logic                nes_clk;
    logic                nes_data;
    logic [NES_BITS-1:0] buttons_in;
    logic [NES_BITS-1:0] snapshot;
    logic                poll_strobe;
    logic                read_done;
    logic [3:0]          bit_cnt;

    modport master (
        output nes_latch, nes_clk, buttons_in,
        input  nes_data, snapshot, poll_strobe, read_done, bit_cnt
    );

    modport slave (
        input  nes_latch, nes_clk, buttons_in,
        output nes_data, snapshot, poll_strobe, read_done, bit_cnt
    );

endinterface

// File: rtl/nes_input_sync.sv
// Synchronizer plus edge detector for one asynchronous host wire (latch or clk).
// Optional glitch filter compiled in with NES_GLITCH_FILTER_EN.
module nes_input_sync #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FILTER_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_s;
    logic                   filt_s;
    logic                   dly_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

`ifdef NES_GLITCH_FILTER_EN
    localparam int unsigned CNT_W = $clog2(FILTER_CYCLES + 1);

    logic             filt_q, filt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Accept a new level only after FILTER_CYCLES consecutive differing samples.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync_s != filt_q) begin
            if (cnt_q == CNT_W'(FILTER_CYCLES - 1)) begin
                filt_d = sync_s;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign filt_s = filt_q;
`else
    localparam int unsigned FILTER_UNUSED = FILTER_CYCLES;

    assign filt_s = sync_s;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dly_q <= 1'b0;
        end else begin
            dly_q <= filt_s;
        end
    end

    assign level_o = filt_s;
    assign rise_o  = filt_s & ~dly_q;
    assign fall_o  = ~filt_s & dly_q;

endmodule

// File: rtl/nes_controller_device.sv
// NES controller emulation (4021-style PISO) driven by an external host's latch/clk.
// Build option: NES_GLITCH_FILTER_EN adds a FILTER_CYCLES-deep glitch filter on both host wires.
//
// state | meaning
// IDLE  | frame finished or never started; stray host clocks keep draining the register
// LOAD  | latch high, register transparently loads buttons_in every cycle
// SHIFT | frame in progress, each host clk rise presents the next bit
module nes_controller_device
    import nes_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FILTER_CYCLES = 4,
    parameter int unsigned FILL_PRESSED  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    nes_controller_device_if.slave  bus
);

    localparam logic FILL_BIT = (FILL_PRESSED != 0);

    logic latch_s, latch_rise, latch_fall;
    logic clk_s, clk_rise, clk_fall;
    logic sync_unused;

    nes_input_sync #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_latch_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (bus.nes_latch),
        .level_o (latch_s),
        .rise_o  (latch_rise),
        .fall_o  (latch_fall)
    );

    nes_input_sync #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_clk_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (bus.nes_clk),
        .level_o (clk_s),
        .rise_o  (clk_rise),
        .fall_o  (clk_fall)
    );

    assign sync_unused = latch_rise | clk_s | clk_fall;

    nes_state_e          state_q, state_d;
    logic [NES_BITS-1:0] shift_q, shift_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [NES_BITS-1:0] snap_q, snap_d;
    logic                poll_q, poll_d;
    logic                done_q, done_d;

    logic [NES_BITS-1:0] shifted;
    logic [3:0]          cnt_inc;

    assign shifted = {FILL_BIT, shift_q[NES_BITS-1:1]};
    assign cnt_inc = (cnt_q >= BIT_FILL) ? BIT_FILL : cnt_q + 4'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            snap_q  <= '0;
            poll_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            poll_q  <= poll_d;
            done_q  <= done_d;
        end
    end

    // Latch level dominates any clock edge; in LOAD a coincident clk_rise is dropped.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        poll_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE, SHIFT: begin
                if (latch_s) begin
                    state_d = LOAD;
                    shift_d = bus.buttons_in;
                    cnt_d   = '0;
                end else if (clk_rise) begin
                    shift_d = shifted;
                    cnt_d   = cnt_inc;
                    done_d  = (cnt_q == BIT_LAST - 4'd1);
                    if (cnt_inc == BIT_FILL) begin
                        state_d = IDLE;
                    end
                end
            end
            LOAD: begin
                shift_d = bus.buttons_in;
                cnt_d   = '0;
                if (latch_fall) begin
                    state_d = SHIFT;
                    snap_d  = bus.buttons_in;
                    poll_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.nes_data    = ~shift_q[0];
        bus.snapshot    = snap_q;
        bus.poll_strobe = poll_q;
        bus.read_done   = done_q;
        bus.bit_cnt     = cnt_q;
    end

endmodule

// File: tb/tb_nes_controller_device.sv
// Scoreboard bench for nes_controller_device: stimulus queues expected host-visible samples,
// monitors pop them on host clk rises, poll_strobe and read_done.
module tb_nes_controller_device;
    import nes_pkg::*;

    localparam int unsigned TB_FILL = 1;
    localparam logic FILL_DATA = (TB_FILL != 0) ? 1'b0 : 1'b1;

    typedef struct packed {
        logic       d;
        logic [3:0] c;
    } bit_exp_t;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    bit_exp_t   q_bit[$];
    logic [7:0] q_snap[$];
    logic       q_done[$];

    nes_controller_device_if ifc ();

    nes_controller_device #(
        .SYNC_STAGES   (2),
        .FILTER_CYCLES (4),
        .FILL_PRESSED  (TB_FILL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Host samples nes_data at each clk rise, before the device shifts.
    always @(posedge ifc.nes_clk) begin
        bit_exp_t e;
        if (q_bit.size() == 0) begin
            check("bit_unexpected", 8'd1, 8'd0);
        end else begin
            e = q_bit.pop_front();
            check("nes_data", {7'd0, ifc.nes_data}, {7'd0, e.d});
            check("bit_cnt", {4'd0, ifc.bit_cnt}, {4'd0, e.c});
        end
    end

    always @(negedge clk) begin
        if (!reset && ifc.poll_strobe) begin
            if (q_snap.size() == 0) check("poll_unexpected", 8'd1, 8'd0);
            else check("snapshot", ifc.snapshot, q_snap.pop_front());
        end
        if (!reset && ifc.read_done) begin
            if (q_done.size() == 0) begin
                check("done_unexpected", 8'd1, 8'd0);
            end else begin
                check("done_data", {7'd0, ifc.nes_data}, {7'd0, q_done.pop_front()});
                check("done_cnt", {4'd0, ifc.bit_cnt}, 8'd7);
            end
        end
    end

    task automatic host_latch(input logic [7:0] btn, input int hold);
        @(negedge clk);
        ifc.buttons_in = btn;
        q_snap.push_back(btn);
        ifc.nes_latch = 1'b1;
        wait_cyc(hold);
        ifc.nes_latch = 1'b0;
        wait_cyc(300);
    endtask

    task automatic host_pulse(input logic d, input logic [3:0] c, input int hi, input int lo);
        q_bit.push_back('{d: d, c: c});
        @(negedge clk);
        ifc.nes_clk = 1'b1;
        wait_cyc(hi);
        ifc.nes_clk = 1'b0;
        wait_cyc(lo);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_data"}, {7'd0, ifc.nes_data}, 8'd1);
        check({tag, "_cnt"}, {4'd0, ifc.bit_cnt}, 8'd0);
        check({tag, "_snap"}, ifc.snapshot, 8'h00);
        check({tag, "_strobes"}, {6'd0, ifc.poll_strobe, ifc.read_done}, 8'd0);
    endtask

    initial begin
        logic seq85 [8];
        logic [3:0] k;
        seq85 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        reset          = 1'b1;
        ifc.nes_latch  = 1'b0;
        ifc.nes_clk    = 1'b0;
        ifc.buttons_in = 8'h00;
        wait_cyc(4);
        reset = 1'b0;
        wait_cyc(10);
        check_reset_values("reset");

        // 0x85 frame: A, Select, Right pressed
        host_latch(8'b1000_0101, 600);
        for (int i = 0; i < 7; i++) begin
            k = 4'(i);
            if (i == 6) q_done.push_back(seq85[7]);
            host_pulse(seq85[i], k, 300, 300);
        end

        // extra pulses: bit 7, then saturated fill
        host_pulse(seq85[7], 4'd7, 300, 300);
        host_pulse(FILL_DATA, 4'd8, 300, 300);
        host_pulse(FILL_DATA, 4'd8, 300, 300);
        check("fill_cnt", {4'd0, ifc.bit_cnt}, 8'd8);
        check("fill_data", {7'd0, ifc.nes_data}, {7'd0, FILL_DATA});

        // transparent load while latch is high; clocks ignored
        @(negedge clk);
        ifc.buttons_in = 8'h01;
        ifc.nes_latch  = 1'b1;
        wait_cyc(100);
        host_pulse(1'b0, 4'd0, 50, 50);
        ifc.buttons_in = 8'h02;
        wait_cyc(20);
        check("load_track", {7'd0, ifc.nes_data}, 8'd1);
        host_pulse(1'b1, 4'd0, 50, 50);
        q_snap.push_back(8'h02);
        ifc.nes_latch = 1'b0;
        wait_cyc(300);

        // three bits of 0x02, then reset mid-frame
        host_pulse(1'b1, 4'd0, 300, 300);
        host_pulse(1'b0, 4'd1, 300, 300);
        host_pulse(1'b1, 4'd2, 300, 100);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_values("midreset");
        wait_cyc(5);
        reset = 1'b0;
        wait_cyc(10);

        host_latch(8'hFF, 600);
        for (int i = 0; i < 8; i++) begin
            k = 4'(i);
            if (i == 6) q_done.push_back(1'b0);
            host_pulse(1'b0, k, 300, 300);
        end
        check("ff_end_cnt", {4'd0, ifc.bit_cnt}, 8'd8);

`ifdef NES_GLITCH_FILTER_EN
        host_latch(8'h05, 600);
        host_pulse(1'b0, 4'd0, 2, 50);
        host_pulse(1'b0, 4'd0, 10, 50);
        check("glitch_one_shift", {4'd0, ifc.bit_cnt}, 8'd1);
        host_pulse(1'b1, 4'd1, 2, 50);
        host_pulse(1'b1, 4'd1, 10, 50);
        check("glitch_two_shift", {4'd0, ifc.bit_cnt}, 8'd2);
`endif

        wait_cyc(20);
        check("bit_queue_left", 8'(q_bit.size()), 8'd0);
        check("snap_queue_left", 8'(q_snap.size()), 8'd0);
        check("done_queue_left", 8'(q_done.size()), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
